alu_mul_ctrl: RTL and testbench

Multi-cycle sequencer that computes the low 64 bits of an unsigned 64×64 product by driving the shared combinational `alu` with shift-add micro-operations. It sits beside `alu`: it owns the `alu` FS/A/B/Cin inputs and consumes F/Cout. Requesters use a start/busy/done handshake. The block adds no arithmetic of its own beyond counters and zero/MSB checks.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_mul_ctrl.sv | 167 ++++++++++++++++
 tb/tb_alu_mul_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the combinational alu and the blocks that drive it.
//   - FS function codes: FS[4:2] selects the function, FS[1] inverts A,
//     FS[0] inverts B.
//   - State encoding for the alu_mul_ctrl multiply sequencer.
//   - Bit positions of the {Z,N,C,V} status vector.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Function field FS[4:2]
    localparam logic [2:0] FN_AND = 3'b000;
    localparam logic [2:0] FN_OR  = 3'b001;
    localparam logic [2:0] FN_ADD = 3'b010;
    localparam logic [2:0] FN_XOR = 3'b011;
    localparam logic [2:0] FN_SHL = 3'b100;
    localparam logic [2:0] FN_SHR = 3'b101;

    // Operand invert controls inside FS
    localparam int FS_INV_A_BIT = 1;
    localparam int FS_INV_B_BIT = 0;

    // Complete FS codes with both invert bits clear
    localparam logic [4:0] FS_AND = {FN_AND, 2'b00};
    localparam logic [4:0] FS_OR  = {FN_OR,  2'b00};
    localparam logic [4:0] FS_ADD = {FN_ADD, 2'b00};
    localparam logic [4:0] FS_XOR = {FN_XOR, 2'b00};
    localparam logic [4:0] FS_SHL = {FN_SHL, 2'b00};
    localparam logic [4:0] FS_SHR = {FN_SHR, 2'b00};

    // Status vector {Z,N,C,V}
    localparam int STAT_Z = 3;
    localparam int STAT_N = 2;
    localparam int STAT_C = 1;
    localparam int STAT_V = 0;

    // Multiply sequencer states
    typedef enum logic [2:0] {
        MUL_IDLE = 3'd0,
        MUL_ADD  = 3'd1,
        MUL_SHL  = 3'd2,
        MUL_SHR  = 3'd3,
        MUL_DONE = 3'd4
    } mul_state_e;

endpackage

// File: rtl/alu_mul_ctrl.sv
// -----------------------------------------------------------------------------
// alu_mul_ctrl
// Shift-add sequencer computing the low 64 bits of an unsigned 64x64 product
// by issuing one micro-operation per cycle to the shared combinational alu.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, sampled only while idle
//   op_a, op_b          multiplicand, multiplier
//   busy                high from the first micro-op through the done cycle
//   done                one-cycle completion pulse
//   product, ovf        registered result and overflow, held until next done
//   alu_fs/a/b/cin      drive the alu inputs (all zero while idle)
//   alu_f, alu_cout     alu result and carry out
//
// Build option:
//   ALU_MUL_EARLY_EXIT_EN  when defined, the loop stops as soon as the
//                          remaining multiplier is zero; otherwise all 64
//                          multiplier bits are always visited.
// -----------------------------------------------------------------------------
module alu_mul_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic        ovf,
    output logic [4:0]  alu_fs,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic        alu_cin,
    input  logic [63:0] alu_f,
    input  logic        alu_cout
);

    mul_state_e  state;
    mul_state_e  state_next;

    logic [63:0] mcand;
    logic [63:0] mplier;
    logic [63:0] acc;
    logic [5:0]  iter;
    logic        ovf_r;
    logic        exit_now;

    // The SHR micro-op result is the shifted multiplier, so alu_f == 0 means
    // no set bits remain and further iterations cannot change acc.
`ifdef ALU_MUL_EARLY_EXIT_EN
    assign exit_now = (iter == 6'd63) || (alu_f == 64'd0);
`else
    assign exit_now = (iter == 6'd63);
`endif

    assign alu_cin = 1'b0;
    assign busy    = (state != MUL_IDLE);
    assign done    = (state == MUL_DONE);

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        alu_fs     = FS_AND;
        alu_a      = 64'd0;
        alu_b      = 64'd0;

        case (state)
            MUL_IDLE: begin
                if (start) begin
                    state_next = op_b[0] ? MUL_ADD : MUL_SHL;
                end
            end
            MUL_ADD: begin
                alu_fs     = FS_ADD;
                alu_a      = acc;
                alu_b      = mcand;
                state_next = MUL_SHL;
            end
            MUL_SHL: begin
                alu_fs     = FS_SHL;
                alu_a      = mcand;
                alu_b      = 64'd1;
                state_next = MUL_SHR;
            end
            MUL_SHR: begin
                alu_fs = FS_SHR;
                alu_a  = mplier;
                alu_b  = 64'd1;
                if (exit_now) begin
                    state_next = MUL_DONE;
                end else begin
                    // alu_f[0] is the next multiplier bit to be examined
                    state_next = alu_f[0] ? MUL_ADD : MUL_SHL;
                end
            end
            MUL_DONE: begin
                state_next = MUL_IDLE;
            end
            default: begin
                state_next = MUL_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= 64'd0;
            mplier  <= 64'd0;
            acc     <= 64'd0;
            iter    <= 6'd0;
            ovf_r   <= 1'b0;
            product <= 64'd0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= 64'd0;
                        iter   <= 6'd0;
                        ovf_r  <= 1'b0;
                    end
                end
                MUL_ADD: begin
                    acc <= alu_f;
                    if (alu_cout) begin
                        ovf_r <= 1'b1;
                    end
                end
                MUL_SHL: begin
                    mcand <= alu_f;
                    // A multiplicand bit shifted out past bit 63 matters only
                    // if a higher multiplier bit would still add it in.
                    if (mcand[63] && (mplier[63:1] != 63'd0)) begin
                        ovf_r <= 1'b1;
                    end
                end
                MUL_SHR: begin
                    mplier <= alu_f;
                    iter   <= iter + 6'd1;
                end
                MUL_DONE: begin
                    product <= acc;
                    ovf     <= ovf_r;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_ctrl
// Bench for alu_mul_ctrl with a behavioural alu closing the loop. Expected
// results and completion cycles are queued when an operation is launched and
// compared when done fires. Honours ALU_MUL_EARLY_EXIT_EN for latency.
// -----------------------------------------------------------------------------
module tb_alu_mul_ctrl;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        ovf;
    logic [4:0]  alu_fs;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic        alu_cin;
    logic [63:0] alu_f;
    logic        alu_cout;

    alu_mul_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .ovf      (ovf),
        .alu_fs   (alu_fs),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_f    (alu_f),
        .alu_cout (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational alu
    logic [63:0] ma;
    logic [63:0] mb;
    logic [64:0] msum;
    always_comb begin
        ma       = alu_fs[FS_INV_A_BIT] ? ~alu_a : alu_a;
        mb       = alu_fs[FS_INV_B_BIT] ? ~alu_b : alu_b;
        msum     = {1'b0, ma} + {1'b0, mb} + {64'd0, alu_cin};
        alu_f    = 64'd0;
        alu_cout = 1'b0;
        case (alu_fs[4:2])
            FN_AND: alu_f = ma & mb;
            FN_OR:  alu_f = ma | mb;
            FN_XOR: alu_f = ma ^ mb;
            FN_ADD: {alu_cout, alu_f} = msum;
            FN_SHL: alu_f = ma << mb[5:0];
            FN_SHR: alu_f = ma >> mb[5:0];
            default: alu_f = 64'd0;
        endcase
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] prod;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] prod;
        logic        ovf;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    // Completion cycle number (cycle 1 = first micro-op) for multiplier b
    function automatic int exp_cycles(input logic [63:0] b);
        int iters;
        iters = 64;
`ifdef ALU_MUL_EARLY_EXIT_EN
        iters = 1;
        for (int i = 0; i < 64; i++) begin
            if (b[i]) iters = i + 1;
        end
`endif
        return 2 * iters + $countones(b) + 1;
    endfunction

    function automatic logic [127:0] mul128(input logic [63:0] a, input logic [63:0] b);
        return {64'd0, a} * {64'd0, b};
    endfunction

    // Scoreboard consumer: completion cycle on done, result the cycle after
    logic  chk_pending = 1'b0;
    exp_t  cur;
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_pending) begin
                check("product", product, cur.prod);
                check("ovf", {63'd0, ovf}, {63'd0, cur.ovf});
                check("busy_after_done", {63'd0, busy}, 64'd0);
                chk_pending = 1'b0;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    cur = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(cur.cyc));
                    check("busy_at_done", {63'd0, busy}, 64'd1);
                    chk_pending = 1'b1;
                end
            end
        end
    end

    // Wait for done (bounded), require busy throughout, then step one cycle
    // so the result comparison happens before returning.
    task automatic wait_done();
        bit seen;
        bit busy_ok;
        seen    = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                busy_ok &= busy;
                @(negedge clk);
            end
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        check("busy_during_op", {63'd0, busy_ok}, 64'd1);
        @(negedge clk);
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] p, input logic o);
        exp_t e;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);              // cycle 1
        start = 1'b0;
        e.prod = p;
        e.ovf  = o;
        e.cyc  = cyc + exp_cycles(b) - 1;
        sb.push_back(e);
        wait_done();
    endtask

    initial begin
        exp_t        e;
        int          t0;
        int          n_done;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [127:0] rp;

        vecs[0] = '{64'd3, 64'd5, 64'd15, 1'b0};
        vecs[1] = '{64'hDEAD_BEEF_1234_5678, 64'd0, 64'd0, 1'b0};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1};
        vecs[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
        vecs[4] = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[5] = '{64'd2, 64'h8000_0000_0000_0000, 64'd0, 1'b1};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
        vecs[7] = '{64'h6000_0000_0000_0000, 64'd3, 64'h2000_0000_0000_0000, 1'b1};
        for (int i = 8; i < NVEC; i++) begin
            ra = {$urandom, $urandom};
            rb = {32'd0, $urandom};
            if (i == 9) rb = {$urandom, $urandom};
            rp = mul128(ra, rb);
            vecs[i] = '{ra, rb, rp[63:0], (rp[127:64] != 64'd0)};
        end

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = 64'd0;
        op_b  = 64'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_alu_fs", {59'd0, alu_fs}, 64'd0);
        check("rst_alu_a", alu_a, 64'd0);
        check("rst_alu_b", alu_b, 64'd0);
        check("rst_alu_cin", {63'd0, alu_cin}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].ovf);
        end

        // start held through DONE: second op accepted right after the idle cycle
        @(negedge clk);
        op_a  = 64'd3;
        op_b  = 64'd5;
        start = 1'b1;
        @(negedge clk);
        t0    = cyc;
        op_a  = 64'd2;
        op_b  = 64'd7;
        e     = '{64'd15, 1'b0, t0 + exp_cycles(64'd5) - 1};
        sb.push_back(e);
        e     = '{64'd14, 1'b0, t0 + exp_cycles(64'd5) + exp_cycles(64'd7)};
        sb.push_back(e);
        wait_done();
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // start pulsed while busy must be ignored
        @(negedge clk);
        op_a  = 64'd3;
        op_b  = 64'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e     = '{64'd15, 1'b0, cyc + exp_cycles(64'd5) - 1};
        sb.push_back(e);
        @(negedge clk);
        op_a  = 64'd7;
        op_b  = 64'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        check("sb_empty_after_ignored_start", 64'(sb.size()), 64'd0);

        // Reset in cycle 4 aborts with no done
        @(negedge clk);
        op_a  = 64'hFFFF_FFFF;
        op_b  = 64'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);              // cycle 1
        start = 1'b0;
        repeat (3) @(negedge clk);   // cycle 4
        check("pre_abort_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        check("abort_alu_fs", {59'd0, alu_fs}, 64'd0);
        check("abort_alu_a", alu_a, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("no_done_after_abort", 64'(n_done), 64'd0);

        // Recovery after abort
        run_op(64'd3, 64'd5, 64'd15, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
